// File: rtl/vector_cordic_arbiter_if.sv
// -----------------------------------------------------------------------------
// vector_cordic_arbiter_if
// Bundles the requester, response and engine signals of the shared vectoring
// CORDIC arbiter.
//   req_valid/req_ready : per-requester job handshake (ready is one-hot)
//   req_x/req_y         : packed operands, requester i at [i*WordLength +: WordLength]
//   rsp_*               : single response port (valid/ready, id, magnitude, angle)
//   eng_*               : launch pulse, operands and results of the CORDIC engine
// Modports:
//   slave  : the arbiter's view
//   master : the environment's view (requesters, response sink, engine)
// -----------------------------------------------------------------------------
interface vector_cordic_arbiter_if #(
  parameter int NREQ       = 4,
  parameter int WordLength = 28
);
  logic [NREQ-1:0]            req_valid;
  logic [NREQ-1:0]            req_ready;
  logic [NREQ*WordLength-1:0] req_x;
  logic [NREQ*WordLength-1:0] req_y;
  logic                       rsp_valid;
  logic                       rsp_ready;
  logic [2:0]                 rsp_id;
  logic [WordLength-1:0]      rsp_mag;
  logic [WordLength-1:0]      rsp_theta;
  logic                       eng_start;
  logic [WordLength-1:0]      eng_x0;
  logic [WordLength-1:0]      eng_y0;
  logic [WordLength-1:0]      eng_xn;
  logic [WordLength-1:0]      eng_thetan;

  modport slave (
    input  req_valid, req_x, req_y, rsp_ready, eng_xn, eng_thetan,
    output req_ready, rsp_valid, rsp_id, rsp_mag, rsp_theta,
           eng_start, eng_x0, eng_y0
  );

  modport master (
    output req_valid, req_x, req_y, rsp_ready, eng_xn, eng_thetan,
    input  req_ready, rsp_valid, rsp_id, rsp_mag, rsp_theta,
           eng_start, eng_x0, eng_y0
  );
endinterface

// File: rtl/vector_cordic_arbiter.sv
// -----------------------------------------------------------------------------
// vector_cordic_arbiter
// Shares one iterative vectoring CORDIC engine between NREQ requesters.
// Round-robin grant in IDLE, folds left-half-plane vectors into the engine's
// convergence range, waits the fixed engine latency, applies the +/-pi
// quadrant correction and returns magnitude, angle and requester id.
// Ports:
//   clock  : system clock, rising edge
//   Areset : asynchronous active-low reset
//   busy   : high in every state except IDLE
//   bus    : vector_cordic_arbiter_if.slave (request, response, engine signals)
// -----------------------------------------------------------------------------
module vector_cordic_arbiter #(
  parameter int                    NREQ       = 4,
  parameter int                    WordLength = 28,
  parameter int                    CORDIC_LAT = 34,
  parameter logic [WordLength-1:0] PI_Q       = 28'd51472
) (
  input  logic                   clock,
  input  logic                   Areset,
  output logic                   busy,
  vector_cordic_arbiter_if.slave bus
);

  localparam int IDXW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int IDXW1 = IDXW + 1;
  localparam int CNTW  = (CORDIC_LAT > 1) ? $clog2(CORDIC_LAT) : 1;

  localparam logic [IDXW:0]   NREQ_W   = IDXW1'(NREQ);
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NREQ - 1);
  localparam logic [IDXW-1:0] IDX_ONE  = IDXW'(1);
  localparam logic [CNTW-1:0] CNT_LOAD = CNTW'(CORDIC_LAT - 1);
  localparam logic [CNTW-1:0] CNT_ZERO = CNTW'(0);
  localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t                state_r;
  logic [IDXW-1:0]       rr_ptr_r;
  logic [IDXW-1:0]       id_r;
  logic                  neg_r;
  logic                  ysgn_r;
  logic [CNTW-1:0]       wait_cnt_r;
  logic                  busy_r;
  logic                  eng_start_r;
  logic [WordLength-1:0] eng_x0_r;
  logic [WordLength-1:0] eng_y0_r;
  logic                  rsp_valid_r;
  logic [WordLength-1:0] rsp_mag_r;
  logic [WordLength-1:0] rsp_theta_r;

  logic                  grant_hit_s;
  logic [IDXW-1:0]       grant_idx_s;
  logic [IDXW:0]         cand_s;
  logic [NREQ-1:0]       ready_s;
  logic [WordLength-1:0] sel_x_s;
  logic [WordLength-1:0] sel_y_s;
  logic                  neg_s;
  logic [WordLength-1:0] fold_x_s;
  logic [WordLength-1:0] fold_y_s;
  logic [WordLength-1:0] theta_fix_s;

  // Round-robin search: first valid requester at or above rr_ptr_r, with wrap.
  always_comb begin
    grant_hit_s = 1'b0;
    grant_idx_s = '0;
    cand_s      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand_s = {1'b0, rr_ptr_r} + IDXW1'(k);
      if (cand_s >= NREQ_W) begin
        cand_s = cand_s - NREQ_W;
      end else begin
        cand_s = cand_s;
      end
      if (!grant_hit_s && bus.req_valid[cand_s[IDXW-1:0]]) begin
        grant_hit_s = 1'b1;
        grant_idx_s = cand_s[IDXW-1:0];
      end else begin
        grant_hit_s = grant_hit_s;
      end
    end
  end

  // One-hot accept strobe, only in IDLE; gated by reset so it reads 0 while held.
  always_comb begin
    ready_s = '0;
    if (Areset && (state_r == S_IDLE) && grant_hit_s) begin
      ready_s[grant_idx_s] = 1'b1;
    end else begin
      ready_s = '0;
    end
  end

  // Operand mux for the granted requester.
  always_comb begin
    sel_x_s = '0;
    sel_y_s = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (grant_idx_s == IDXW'(k)) begin
        sel_x_s = bus.req_x[k*WordLength +: WordLength];
        sel_y_s = bus.req_y[k*WordLength +: WordLength];
      end else begin
        sel_x_s = sel_x_s;
        sel_y_s = sel_y_s;
      end
    end
  end

  // Left-half-plane fold: rotating by pi (negating both) puts x in the engine's range.
  always_comb begin
    neg_s = sel_x_s[WordLength-1];
    if (neg_s) begin
      fold_x_s = -sel_x_s;
      fold_y_s = -sel_y_s;
    end else begin
      fold_x_s = sel_x_s;
      fold_y_s = sel_y_s;
    end
  end

  // Undo the fold on the angle: the sign of the original y picks +pi or -pi,
  // which keeps the result inside (-pi, pi].
  always_comb begin
    if (!neg_r) begin
      theta_fix_s = bus.eng_thetan;
    end else if (ysgn_r) begin
      theta_fix_s = bus.eng_thetan - PI_Q;
    end else begin
      theta_fix_s = bus.eng_thetan + PI_Q;
    end
  end

  // Job sequencer: accept, launch, wait engine latency, hold response until taken.
  always_ff @(posedge clock or negedge Areset) begin
    if (!Areset) begin
      state_r     <= S_IDLE;
      rr_ptr_r    <= '0;
      id_r        <= '0;
      neg_r       <= 1'b0;
      ysgn_r      <= 1'b0;
      wait_cnt_r  <= '0;
      busy_r      <= 1'b0;
      eng_start_r <= 1'b0;
      eng_x0_r    <= '0;
      eng_y0_r    <= '0;
      rsp_valid_r <= 1'b0;
      rsp_mag_r   <= '0;
      rsp_theta_r <= '0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (grant_hit_s) begin
            id_r        <= grant_idx_s;
            neg_r       <= neg_s;
            ysgn_r      <= sel_y_s[WordLength-1];
            eng_x0_r    <= fold_x_s;
            eng_y0_r    <= fold_y_s;
            eng_start_r <= 1'b1;
            busy_r      <= 1'b1;
            state_r     <= S_LAUNCH;
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_LAUNCH: begin
          eng_start_r <= 1'b0;
          wait_cnt_r  <= CNT_LOAD;
          state_r     <= S_WAIT;
        end
        S_WAIT: begin
          if (wait_cnt_r == CNT_ZERO) begin
            rsp_mag_r   <= bus.eng_xn;
            rsp_theta_r <= theta_fix_s;
            rsp_valid_r <= 1'b1;
            state_r     <= S_RESP;
          end else begin
            wait_cnt_r <= wait_cnt_r - CNT_ONE;
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            state_r     <= S_IDLE;
            if (id_r == IDX_LAST) begin
              rr_ptr_r <= '0;
            end else begin
              rr_ptr_r <= id_r + IDX_ONE;
            end
          end else begin
            state_r <= S_RESP;
          end
        end
        default: begin
          state_r     <= S_IDLE;
          busy_r      <= 1'b0;
          eng_start_r <= 1'b0;
          rsp_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign busy          = busy_r;
  assign bus.req_ready = ready_s;
  assign bus.eng_start = eng_start_r;
  assign bus.eng_x0    = eng_x0_r;
  assign bus.eng_y0    = eng_y0_r;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_id    = 3'(id_r);
  assign bus.rsp_mag   = rsp_mag_r;
  assign bus.rsp_theta = rsp_theta_r;

endmodule

// File: tb/tb_vector_cordic_arbiter.sv
// -----------------------------------------------------------------------------
// tb_vector_cordic_arbiter
// Scoreboard bench: the stimulus process pushes the expected response
// (requester id, |v|, atan2 of the original vector) at each accept; a separate
// monitor pops and compares on every response handshake. A behavioural engine
// presents random values until exactly CORDIC_LAT cycles after launch.
// -----------------------------------------------------------------------------
module tb_vector_cordic_arbiter;

  localparam int NREQ = 4;
  localparam int WL   = 28;
  localparam int LAT  = 34;

  typedef struct {
    int id;
    int mag;
    int theta;
    int acc_cyc;
  } exp_t;

  logic clock;
  logic Areset;
  logic busy;

  vector_cordic_arbiter_if #(.NREQ(NREQ), .WordLength(WL)) bus ();

  vector_cordic_arbiter #(
    .NREQ(NREQ), .WordLength(WL), .CORDIC_LAT(LAT), .PI_Q(28'd51472)
  ) dut (
    .clock(clock),
    .Areset(Areset),
    .busy(busy),
    .bus(bus)
  );

  exp_t exp_q[$];
  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int model_ptr = 0;
  int last_acc_cyc = -1000;
  int acc_x = 0;
  int acc_y = 0;
  int prev_acc = -1;
  bit spacing_mode = 1'b0;
  bit first_after_rst = 1'b0;
  int rr_mode = 0;
  int rem[NREQ];
  int cur_x[NREQ];
  int cur_y[NREQ];
  logic [NREQ-1:0] vld;

  // monitor state
  bit mon_pv = 1'b0;
  bit mon_phs = 1'b0;
  logic [2:0] mon_id;
  logic [WL-1:0] mon_mag;
  logic [WL-1:0] mon_theta;
  exp_t mon_e;

  // engine model state
  bit eng_run = 1'b0;
  int eng_cnt = 0;
  int eng_fmag = 0;
  int eng_fth = 0;
  int eng_lx = 0;
  int eng_ly = 0;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name, input longint act, input longint req);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int ref_mag(input int x, input int y);
    real rx;
    real ry;
    rx = x;
    ry = y;
    return int'($sqrt(rx * rx + ry * ry));
  endfunction

  function automatic int ref_theta(input int x, input int y);
    real rx;
    real ry;
    rx = x;
    ry = y;
    return int'($atan2(ry, rx) * 16384.0);
  endfunction

  function automatic int rnd_op();
    int r;
    r = int'($urandom_range(0, 9));
    if (r == 0) return 0;
    if (r == 1) return int'($urandom_range(0, 64)) - 32;
    return int'($urandom_range(0, 33554432)) - 16777216;
  endfunction

  function automatic int exp_grant(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      bus.req_x[i*WL +: WL] = WL'(cur_x[i]);
      bus.req_y[i*WL +: WL] = WL'(cur_y[i]);
    end
    bus.req_valid = vld;
    if (rr_mode == 0) bus.rsp_ready = 1'b1;
    else if (rr_mode == 1) bus.rsp_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic accept(input int i);
    exp_t e;
    e.id = i;
    e.mag = ref_mag(cur_x[i], cur_y[i]);
    e.theta = ref_theta(cur_x[i], cur_y[i]);
    e.acc_cyc = cyc;
    exp_q.push_back(e);
    if (spacing_mode && prev_acc >= 0) chk((cyc - prev_acc) == LAT + 3, "accept_spacing", cyc - prev_acc, LAT + 3);
    if (first_after_rst) begin
      chk(i == 1, "first_grant_after_reset", i, 1);
      first_after_rst = 1'b0;
    end
    prev_acc = cyc;
    last_acc_cyc = cyc;
    acc_x = cur_x[i];
    acc_y = cur_y[i];
    if (rem[i] > 0) rem[i]--;
    if (rem[i] > 0) begin
      cur_x[i] = rnd_op();
      cur_y[i] = rnd_op();
    end else begin
      vld[i] = 1'b0;
    end
  endtask

  task automatic step();
    int g;
    logic [NREQ-1:0] want;
    @(negedge clock);
    g = exp_grant(bus.req_valid, model_ptr);
    want = '0;
    if (Areset && !busy && g >= 0) want[g] = 1'b1;
    chk(bus.req_ready == want, "req_ready_grant", bus.req_ready, want);
    for (int i = 0; i < NREQ; i++) begin
      if (bus.req_valid[i] && bus.req_ready[i]) accept(i);
    end
    @(posedge clock);
    #1;
    drive();
  endtask

  function automatic bit all_done();
    for (int i = 0; i < NREQ; i++) if (rem[i] != 0) return 1'b0;
    return (exp_q.size() == 0) && !busy;
  endfunction

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (!all_done()) begin
      if (n >= budget) begin
        chk(1'b0, "idle_timeout", n, budget);
        return;
      end
      step();
      n++;
    end
  endtask

  task automatic job(input int i, input int x, input int y);
    cur_x[i] = x;
    cur_y[i] = y;
    rem[i] = 1;
    vld[i] = 1'b1;
    wait_idle(200);
  endtask

  task automatic chk_zero(input string tag);
    chk(bus.req_ready == '0, {tag, "_req_ready"}, bus.req_ready, 0);
    chk(bus.rsp_valid == 1'b0, {tag, "_rsp_valid"}, bus.rsp_valid, 0);
    chk(bus.rsp_id == 3'd0, {tag, "_rsp_id"}, bus.rsp_id, 0);
    chk(bus.rsp_mag == '0, {tag, "_rsp_mag"}, bus.rsp_mag, 0);
    chk(bus.rsp_theta == '0, {tag, "_rsp_theta"}, bus.rsp_theta, 0);
    chk(bus.eng_start == 1'b0, {tag, "_eng_start"}, bus.eng_start, 0);
    chk(bus.eng_x0 == '0, {tag, "_eng_x0"}, bus.eng_x0, 0);
    chk(bus.eng_y0 == '0, {tag, "_eng_y0"}, bus.eng_y0, 0);
    chk(busy == 1'b0, {tag, "_busy"}, busy, 0);
  endtask

  // Behavioural engine: random output until CORDIC_LAT cycles after the launch cycle.
  initial begin
    bus.eng_xn = '0;
    bus.eng_thetan = '0;
    forever begin
      @(negedge clock);
      if (!Areset) begin
        eng_run = 1'b0;
      end else if (bus.eng_start) begin
        chk(cyc == last_acc_cyc + 1, "eng_start_timing", cyc, last_acc_cyc + 1);
        chk(int'($signed(bus.eng_x0)) == ((acc_x < 0) ? -acc_x : acc_x), "eng_x0_fold",
            int'($signed(bus.eng_x0)), (acc_x < 0) ? -acc_x : acc_x);
        chk(int'($signed(bus.eng_y0)) == ((acc_x < 0) ? -acc_y : acc_y), "eng_y0_fold",
            int'($signed(bus.eng_y0)), (acc_x < 0) ? -acc_y : acc_y);
        eng_lx = int'($signed(bus.eng_x0));
        eng_ly = int'($signed(bus.eng_y0));
        eng_fmag = ref_mag(eng_lx, eng_ly);
        eng_fth = ref_theta(eng_lx, eng_ly);
        eng_cnt = 0;
        eng_run = 1'b1;
        bus.eng_xn = WL'($urandom);
        bus.eng_thetan = WL'($urandom);
      end else if (eng_run) begin
        eng_cnt++;
        if (eng_cnt >= LAT) begin
          bus.eng_xn = WL'(eng_fmag);
          bus.eng_thetan = WL'(eng_fth);
          if (eng_cnt == LAT) begin
            chk(int'($signed(bus.eng_x0)) == eng_lx, "eng_x0_held", int'($signed(bus.eng_x0)), eng_lx);
            chk(int'($signed(bus.eng_y0)) == eng_ly, "eng_y0_held", int'($signed(bus.eng_y0)), eng_ly);
          end
        end else begin
          bus.eng_xn = WL'($urandom);
          bus.eng_thetan = WL'($urandom);
        end
      end
    end
  end

  // Response monitor: latency, stability under back-pressure, scoreboard compare.
  initial begin
    forever begin
      @(negedge clock);
      if (!Areset) begin
        exp_q.delete();
        model_ptr = 0;
        mon_pv = 1'b0;
        mon_phs = 1'b0;
      end else begin
        if (mon_phs) chk(!bus.rsp_valid, "rsp_valid_after_handshake", bus.rsp_valid, 0);
        if (mon_pv && !mon_phs) begin
          chk(bus.rsp_valid, "rsp_valid_held", bus.rsp_valid, 1);
          chk(bus.rsp_id == mon_id, "rsp_id_stable", bus.rsp_id, mon_id);
          chk(bus.rsp_mag == mon_mag, "rsp_mag_stable", bus.rsp_mag, mon_mag);
          chk(bus.rsp_theta == mon_theta, "rsp_theta_stable", bus.rsp_theta, mon_theta);
        end
        if (bus.rsp_valid && !mon_pv) begin
          if (exp_q.size() == 0) chk(1'b0, "unexpected_response", bus.rsp_id, -1);
          else chk((cyc - exp_q[0].acc_cyc) == LAT + 2, "rsp_latency", cyc - exp_q[0].acc_cyc, LAT + 2);
        end
        if (bus.rsp_valid && bus.rsp_ready && exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          chk(int'(bus.rsp_id) == mon_e.id, "rsp_id", bus.rsp_id, mon_e.id);
          chk((int'($signed(bus.rsp_mag)) - mon_e.mag) <= 16 && (mon_e.mag - int'($signed(bus.rsp_mag))) <= 16,
              "rsp_mag", int'($signed(bus.rsp_mag)), mon_e.mag);
          chk((int'($signed(bus.rsp_theta)) - mon_e.theta) <= 8 && (mon_e.theta - int'($signed(bus.rsp_theta))) <= 8,
              "rsp_theta", int'($signed(bus.rsp_theta)), mon_e.theta);
          model_ptr = (mon_e.id + 1) % NREQ;
        end
        mon_pv = bus.rsp_valid;
        mon_phs = bus.rsp_valid && bus.rsp_ready;
        mon_id = bus.rsp_id;
        mon_mag = bus.rsp_mag;
        mon_theta = bus.rsp_theta;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit, got %0d cycles", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    Areset = 1'b0;
    vld = '0;
    for (int i = 0; i < NREQ; i++) begin
      rem[i] = 0;
      cur_x[i] = 0;
      cur_y[i] = 0;
    end
    rr_mode = 0;
    drive();
    repeat (3) @(negedge clock);
    chk_zero("reset");
    @(posedge clock);
    #1;
    Areset = 1'b1;

    // directed jobs
    job(0, 16384, 16384);
    job(2, -16384, 0);
    job(1, -16384, -16384);
    job(3, 0, 0);
    job(1, 0, -16384);
    job(2, -100, 5);

    // all four requesters continuously valid, rsp_ready high
    spacing_mode = 1'b1;
    prev_acc = -1;
    for (int i = 0; i < NREQ; i++) begin
      cur_x[i] = rnd_op();
      cur_y[i] = rnd_op();
      rem[i] = 3;
      vld[i] = 1'b1;
    end
    wait_idle(1000);
    spacing_mode = 1'b0;

    // back-pressure: hold rsp_ready low 10 cycles with another request pending
    rr_mode = 2;
    bus.rsp_ready = 1'b0;
    cur_x[2] = rnd_op();
    cur_y[2] = rnd_op();
    rem[2] = 1;
    vld[2] = 1'b1;
    n = 0;
    while (!bus.rsp_valid && n < 100) begin
      step();
      n++;
      if (n == 5) begin
        cur_x[0] = rnd_op();
        cur_y[0] = rnd_op();
        rem[0] = 1;
        vld[0] = 1'b1;
      end
    end
    chk(bus.rsp_valid, "backpressure_rsp_seen", bus.rsp_valid, 1);
    repeat (10) step();
    bus.rsp_ready = 1'b1;
    rr_mode = 0;
    wait_idle(200);

    // randomized traffic with random back-pressure
    rr_mode = 1;
    repeat (8) begin
      for (int i = 0; i < NREQ; i++) begin
        if (rem[i] == 0 && $urandom_range(0, 1) == 1) begin
          rem[i] = int'($urandom_range(1, 2));
          cur_x[i] = rnd_op();
          cur_y[i] = rnd_op();
          vld[i] = 1'b1;
        end
      end
      repeat ($urandom_range(5, 60)) step();
    end
    wait_idle(3000);
    rr_mode = 0;

    // reset mid-WAIT with requester 3 in flight
    cur_x[3] = rnd_op();
    cur_y[3] = rnd_op();
    rem[3] = 1;
    vld[3] = 1'b1;
    n = 0;
    while (rem[3] != 0 && n < 50) begin
      step();
      n++;
    end
    chk(rem[3] == 0, "req3_accepted", rem[3], 0);
    repeat (10) step();
    @(posedge clock);
    #2;
    Areset = 1'b0;
    #1;
    chk_zero("mid_reset");
    last_acc_cyc = -1000;
    first_after_rst = 1'b1;
    for (int i = 1; i < NREQ; i += 2) begin
      cur_x[i] = rnd_op();
      cur_y[i] = rnd_op();
      rem[i] = 1;
      vld[i] = 1'b1;
    end
    drive();
    repeat (3) step();
    Areset = 1'b1;
    wait_idle(300);
    chk(first_after_rst == 1'b0, "grant_after_reset_seen", first_after_rst, 0);

    repeat (5) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vector_cordic_arbiter.md
# vector_cordic_arbiter

Shares one iterative vectoring CORDIC engine (`Vector_CORDIC`) between `NREQ` requesters using round-robin arbitration with valid/ready handshakes on both sides. For each accepted job, the block:

- folds left-half-plane vectors into the engine's convergence range,
- launches the engine and waits its fixed iteration latency,
- applies the ±π quadrant correction to the angle,
- returns magnitude, angle and requester ID on a single response port.

## Interface

Parameters
- `NREQ`, 4, number of requesters (2..8).
- `WordLength`, 28, operand/result width; signed Q14.14.
- `CORDIC_LAT`, 34, cycles from `eng_start` until `eng_xn`/`eng_thetan` are final. Must be ≥ engine stage count N + 2.
- `PI_Q`, 28'd51472, π in Q14.14.

Ports (`reset Areset, asynchronous, active-low; clock clock.`)
- `clock` in 1: system clock, rising edge.
- `Areset` in 1: asynchronous active-low reset.
- `req_valid` in NREQ: per-requester job valid.
- `req_ready` out NREQ: one-hot accept strobe.
- `req_x` in NREQ*WordLength: packed X operands; requester i occupies bits [i*WL +: WL].
- `req_y` in NREQ*WordLength: packed Y operands, same packing as `req_x`.
- `rsp_valid` out 1: result valid.
- `rsp_ready` in 1: result consumer ready.
- `rsp_id` out 3: index of the requester that owns the result.
- `rsp_mag` out WordLength: vector magnitude (already gain-corrected by the engine).
- `rsp_theta` out WordLength: angle in (−π, π], Q14.14.
- `eng_start` out 1: one-cycle launch pulse to the engine `Start`.
- `eng_x0`, `eng_y0` out WordLength: engine operands; held stable from launch until capture.
- `eng_xn`, `eng_thetan` in WordLength: engine results.
- `busy` out 1: high in every state except IDLE.

## Operation

- FSM states: IDLE → LAUNCH → WAIT → RESP → IDLE.
- **IDLE**
  - Grant goes to the first requester with `req_valid` high, searching from `rr_ptr` upward with wrap.
  - `req_ready[grant]` is asserted combinationally in the same cycle; that cycle is the accept.
  - At accept, register the following:
    - the requester ID;
    - the operands;
    - `neg = x[WL-1]`;
    - `ysgn = y[WL-1]`.
  - If `neg` is set, store `eng_x0 = −x` and `eng_y0 = −y`. Otherwise store the operands unmodified.
  - No valid requests: stay in IDLE, all `req_ready` low.
- **LAUNCH**: `eng_start` = 1 for exactly one cycle; load `wait_cnt = CORDIC_LAT−1`.
- **WAIT**
  - Decrement `wait_cnt` each cycle.
  - When it reaches 0, capture results:
    - `rsp_mag = eng_xn`.
    - `rsp_theta = eng_thetan`, plus the correction below when `neg` is set.
  - Correction when `neg` is set: add `PI_Q` if `ysgn` = 0, subtract `PI_Q` if `ysgn` = 1.
  - Theta arithmetic is WordLength-bit two's complement, with no saturation (the range cannot overflow Q14.14).
- **RESP**
  - `rsp_valid` = 1; `rsp_id`, `rsp_mag` and `rsp_theta` are held stable.
  - On `rsp_valid && rsp_ready`: set `rr_ptr = (id+1) mod NREQ` and go to IDLE.
- Edge cases:
  - x = 0, y = 0 → engine result passed through unmodified; ID still returned.
  - x = −2^(WL−1): negation wraps; the result is undefined and is not a verification target.
- Requests arriving while busy are not accepted (`req_ready` = 0). Requesters must hold `req_valid` and their operands stable until accepted.

## Timing

- Reset values: `req_ready` = 0, `rsp_valid` = 0, `rsp_id`/`rsp_mag`/`rsp_theta` = 0, `eng_start` = 0, `eng_x0`/`eng_y0` = 0, `busy` = 0. Reset also sets `rr_ptr` = 0 and state = IDLE.
- Accept at cycle T gives:
  - `eng_start` high at T+1;
  - capture at the edge ending T+1+CORDIC_LAT;
  - `rsp_valid` high from T+2+CORDIC_LAT.
- Earliest next accept is the cycle after the response handshake. Throughput is one job per CORDIC_LAT+3 cycles with `rsp_ready` tied high.
- Back-pressure: `rsp_valid` and its data remain unchanged for as long as `rsp_ready` is low.
- `Areset` asserted mid-job:
  - the job is dropped and no response is produced;
  - `eng_start` does not re-pulse;
  - the first accept after release goes to requester 0 if it is valid.
- Arbitration is evaluated only in IDLE. A `req_valid` that drops before being granted is simply never served.

## Test plan

- Single request from requester 0, x = 16384, y = 16384:
  - one `eng_start` pulse at T+1;
  - `rsp_id` = 0, `rsp_theta` = 12868 ±8, `rsp_mag` = 23170 ±16, `rsp_valid` at T+36.
- Requester 2, x = −16384, y = 0:
  - engine sees x0 = 16384, y0 = 0;
  - `rsp_theta` = 51472 ±8, `rsp_mag` = 16384 ±16, `rsp_id` = 2.
- Requester 1, x = −16384, y = −16384:
  - `rsp_theta` = −38604 ±8 (−3π/4), `rsp_mag` = 23170 ±16.
- All four `req_valid` held high with `rsp_ready` = 1: service order is 0, 1, 2, 3, 0, …
  - `req_ready` is one-hot and never overlaps `busy`;
  - accept-to-accept spacing is 37 cycles.
- `rsp_ready` held low for 10 cycles after `rsp_valid` rises:
  - response data is stable and `req_ready` stays 0 throughout;
  - the handshake completes on the cycle `rsp_ready` rises.
- `Areset` asserted mid-WAIT with requester 3 in flight:
  - all outputs return to 0 immediately;
  - no response is produced for requester 3;
  - after release, with requesters 1 and 3 valid, requester 1 is granted first.
